// File: rtl/gps_correlator_channel.sv
// rtl/gps_correlator_channel.sv - GPS C/A-code prompt correlator channel with carrier and code NCOs
// Purpose: wipes off the carrier using a 4-phase rotation and the selected C/A code, then integrates
//          prompt I/Q over one 1023-chip code epoch. Each epoch result goes to a one-entry
//          valid/ready output register.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   enable              1 = consume one sample per clk (RUN), 0 = IDLE (all channel state cleared)
//   real_in, imag_in    3-bit signed I/Q samples
//   carr_freq           carrier NCO increment per sample (2^32 = one cycle)
//   code_freq           code NCO increment per sample (carry = one chip)
//   ca_sel              PRN select (0..35 -> PRN 1..36, larger values -> PRN 36)
//   acc_i, acc_q        signed epoch integration result, qualified by out_valid
//   out_valid/out_ready output handshake
//   overrun             sticky: an epoch result was dropped because the output was still held
module gps_correlator_channel #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       real_in,
  input  logic [2:0]       imag_in,
  input  logic [31:0]      carr_freq,
  input  logic [31:0]      code_freq,
  input  logic [5:0]       ca_sel,
  output logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] acc_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  logic [31:0]       carr_phase, code_phase;
  logic [32:0]       code_sum;
  logic              code_carry, epoch_end;
  logic [9:0]        g1, g2;        // bit n holds LFSR stage n+1
  logic [9:0]        chip_cnt;
  logic [7:0]        tap_pair;      // {stage_a, stage_b} of the G2 phase-select taps
  logic [3:0]        tap_a, tap_b;
  logic              chip;
  logic signed [3:0] s_i, s_q, rot_i, rot_q, con_i, con_q;

  // stage 1: wiped-off contribution of the sample taken on the previous edge
  logic signed [3:0] p_i, p_q;
  logic              p_last;

  logic [ACC_W-1:0]  accum_i, accum_q, sum_i, sum_q;

  // stage 2: completed epoch result waiting for the output register
  logic              res_valid;
  logic [ACC_W-1:0]  res_i, res_q;

  always_comb begin
    tap_pair = 8'h28;
    case (ca_sel)
      6'd0:  tap_pair = 8'h26;  6'd1:  tap_pair = 8'h37;  6'd2:  tap_pair = 8'h48;
      6'd3:  tap_pair = 8'h59;  6'd4:  tap_pair = 8'h19;  6'd5:  tap_pair = 8'h2A;
      6'd6:  tap_pair = 8'h18;  6'd7:  tap_pair = 8'h29;  6'd8:  tap_pair = 8'h3A;
      6'd9:  tap_pair = 8'h23;  6'd10: tap_pair = 8'h34;  6'd11: tap_pair = 8'h56;
      6'd12: tap_pair = 8'h67;  6'd13: tap_pair = 8'h78;  6'd14: tap_pair = 8'h89;
      6'd15: tap_pair = 8'h9A;  6'd16: tap_pair = 8'h14;  6'd17: tap_pair = 8'h25;
      6'd18: tap_pair = 8'h36;  6'd19: tap_pair = 8'h47;  6'd20: tap_pair = 8'h58;
      6'd21: tap_pair = 8'h69;  6'd22: tap_pair = 8'h13;  6'd23: tap_pair = 8'h46;
      6'd24: tap_pair = 8'h57;  6'd25: tap_pair = 8'h68;  6'd26: tap_pair = 8'h79;
      6'd27: tap_pair = 8'h8A;  6'd28: tap_pair = 8'h16;  6'd29: tap_pair = 8'h27;
      6'd30: tap_pair = 8'h38;  6'd31: tap_pair = 8'h49;  6'd32: tap_pair = 8'h5A;
      6'd33: tap_pair = 8'h4A;  6'd34: tap_pair = 8'h17;
      default: tap_pair = 8'h28;
    endcase
  end

  assign tap_a      = tap_pair[7:4];
  assign tap_b      = tap_pair[3:0];
  assign chip       = g1[9] ^ g2[tap_a - 4'd1] ^ g2[tap_b - 4'd1];
  assign code_sum   = {1'b0, code_phase} + {1'b0, code_freq};
  assign code_carry = code_sum[32];
  assign epoch_end  = code_carry && (chip_cnt == 10'd1022);

  // Samples are widened to 4 bits first, so negating -4 gives +4 instead of wrapping.
  always_comb begin
    s_i   = {real_in[2], real_in};
    s_q   = {imag_in[2], imag_in};
    rot_i = s_i;
    rot_q = s_q;
    case (carr_phase[31:30])
      2'd0: begin rot_i = s_i;  rot_q = s_q;  end
      2'd1: begin rot_i = s_q;  rot_q = -s_i; end
      2'd2: begin rot_i = -s_i; rot_q = -s_q; end
      2'd3: begin rot_i = -s_q; rot_q = s_i;  end
      default: ;
    endcase
    con_i = chip ? -rot_i : rot_i;
    con_q = chip ? -rot_q : rot_q;
  end

  assign sum_i = accum_i + {{(ACC_W-4){p_i[3]}}, p_i};
  assign sum_q = accum_q + {{(ACC_W-4){p_q[3]}}, p_q};

  // Channel state. IDLE clears everything up to and including stage 2, so a partial epoch
  // never produces a result. Stage 1 also clears to zero, so the first RUN edge adds nothing.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      carr_phase <= '0;
      code_phase <= '0;
      g1         <= '1;
      g2         <= '1;
      chip_cnt   <= '0;
      p_i        <= '0;
      p_q        <= '0;
      p_last     <= 1'b0;
      accum_i    <= '0;
      accum_q    <= '0;
      res_valid  <= 1'b0;
      res_i      <= '0;
      res_q      <= '0;
    end else begin
      carr_phase <= carr_phase + carr_freq;
      code_phase <= code_sum[31:0];
      if (epoch_end) begin
        chip_cnt <= '0;
        g1       <= '1;
        g2       <= '1;
      end else if (code_carry) begin
        chip_cnt <= chip_cnt + 10'd1;
        g1       <= {g1[8:0], g1[2] ^ g1[9]};
        g2       <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
      end
      p_i       <= con_i;
      p_q       <= con_q;
      p_last    <= epoch_end;
      res_valid <= p_last;
      if (p_last) begin
        res_i   <= sum_i;
        res_q   <= sum_q;
        accum_i <= '0;
        accum_q <= '0;
      end else begin
        accum_i <= sum_i;
        accum_q <= sum_q;
      end
    end
  end

  // The output register keeps running its handshake in IDLE. A result that arrives while the
  // held result is still unaccepted is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      acc_i     <= '0;
      acc_q     <= '0;
      overrun   <= 1'b0;
    end else if (res_valid) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        acc_i     <= res_i;
        acc_q     <= res_q;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gps_correlator_channel.sv
// tb/tb_gps_correlator_channel.sv - self-checking bench for gps_correlator_channel
module tb_gps_correlator_channel;

  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             reset, enable, out_ready;
  logic [2:0]       real_in, imag_in;
  logic [31:0]      carr_freq, code_freq;
  logic [5:0]       ca_sel;
  logic [ACC_W-1:0] acc_i, acc_q;
  logic             out_valid, overrun;

  gps_correlator_channel #(.ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .real_in(real_in), .imag_in(imag_in),
    .carr_freq(carr_freq), .code_freq(code_freq), .ca_sel(ca_sel),
    .acc_i(acc_i), .acc_q(acc_q), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic longint trunc(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return t;
  endfunction

  // Code sequences as recurrences on output bit streams:
  // G1 output s(n+10) = s(n+7) ^ s(n); G2 stage k at chip t is u(t+10-k).
  bit         s_seq [0:1040];
  bit         u_seq [0:1040];
  logic [7:0] tap_tbl [0:35];

  // Behavioural model: channel state advanced on each edge from the sampled inputs.
  typedef struct { longint due; longint ri; longint rq; } res_t;
  res_t   pend[$];
  longint cyc = 0;
  longint m_cph = 0, m_dph = 0, m_ai = 0, m_aq = 0, m_oi = 0, m_oq = 0;
  int     m_idx = 0;
  bit     m_v = 0, m_ov = 0;
  int     mp, mc, mi, mq, mt, mk;
  longint msum;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      m_cph = 0; m_dph = 0; m_ai = 0; m_aq = 0; m_idx = 0;
      m_v = 0; m_ov = 0; m_oi = 0; m_oq = 0;
    end else begin
      // A result needs enable on the edge after its last sample, or it is discarded.
      if (!enable)
        for (int j = pend.size() - 1; j >= 0; j--)
          if (pend[j].due == cyc + 1) pend.delete(j);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (!m_v || out_ready) begin
          m_v = 1; m_oi = pend[0].ri; m_oq = pend[0].rq;
        end else begin
          m_ov = 1;
        end
        void'(pend.pop_front());
      end else if (out_ready) begin
        m_v = 0;
      end
      if (enable) begin
        mp = (ca_sel > 35) ? 35 : int'(ca_sel);
        mc = int'(s_seq[m_idx] ^ u_seq[m_idx + 10 - int'(tap_tbl[mp][7:4])]
                               ^ u_seq[m_idx + 10 - int'(tap_tbl[mp][3:0])]);
        mi = int'($signed(real_in));
        mq = int'($signed(imag_in));
        mk = int'((m_cph >> 30) & 3);
        for (int r = 0; r < mk; r++) begin
          mt = mi; mi = mq; mq = -mt;
        end
        m_ai += (mc != 0) ? -mi : mi;
        m_aq += (mc != 0) ? -mq : mq;
        m_cph = (m_cph + longint'(carr_freq)) % 64'h1_0000_0000;
        msum  = m_dph + longint'(code_freq);
        m_dph = msum % 64'h1_0000_0000;
        if (msum >= 64'h1_0000_0000) begin
          if (m_idx == 1022) begin
            pend.push_back('{cyc + 2, m_ai, m_aq});
            m_ai = 0; m_aq = 0; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end else begin
        m_cph = 0; m_dph = 0; m_ai = 0; m_aq = 0; m_idx = 0;
      end
    end
    #3;
    check("out_valid", out_valid, m_v);
    check("overrun", overrun, m_ov);
    check("acc_i", $signed(acc_i), trunc(m_oi));
    check("acc_q", $signed(acc_q), trunc(m_oq));
  end

  task automatic wait_valid(input int budget, output longint at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1; at = cyc; break;
      end
    end
  endtask

  longint     first, at, at2;
  bit         ok;
  logic [9:0] chips10;
  longint     pi, pq, ci, cq;
  int         exp_di [4];
  int         exp_dq [4];
  int         idle_left;

  initial begin
    for (int n = 0; n < 10; n++) begin s_seq[n] = 1; u_seq[n] = 1; end
    for (int n = 0; n + 10 <= 1040; n++) begin
      s_seq[n+10] = s_seq[n+7] ^ s_seq[n];
      u_seq[n+10] = u_seq[n+8] ^ u_seq[n+7] ^ u_seq[n+4] ^ u_seq[n+2] ^ u_seq[n+1] ^ u_seq[n];
    end
    tap_tbl = '{8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29, 8'h3A, 8'h23, 8'h34, 8'h56,
                8'h67, 8'h78, 8'h89, 8'h9A, 8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
                8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49, 8'h5A, 8'h4A, 8'h17, 8'h28};
    exp_di = '{-1, 0, 1, 0};
    exp_dq = '{0, 1, 0, -1};

    reset = 1; enable = 1; out_ready = 1; real_in = 3'd1; imag_in = 3'd0;
    carr_freq = 32'd0; code_freq = 32'h8000_0000; ca_sel = 6'd0;

    for (int j = 0; j < 10; j++)
      chips10[9-j] = s_seq[j] ^ u_seq[j+8] ^ u_seq[j+4];
    check("prn1_first10_chips", chips10, 10'b1100100000);

    // Reset held with enable high: outputs stay zero.
    repeat (4) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_acc_i", acc_i, 0);
      check("rst_overrun", overrun, 0);
    end
    reset = 0; first = cyc + 1;
    wait_valid(2100, at, ok);
    check("base_result_seen", ok, 1);
    check("base_latency", at - first, 2047);
    check("base_acc_i", $signed(acc_i), -2);
    check("base_acc_q", $signed(acc_q), 0);
    check("base_overrun", overrun, 0);

    // Most negative sample: +8, repeating each epoch.
    @(negedge clk); reset = 1; real_in = 3'b100;
    @(negedge clk); reset = 0; first = cyc + 1;
    wait_valid(2100, at, ok);
    check("neg4_seen", ok, 1);
    check("neg4_latency", at - first, 2047);
    check("neg4_acc_i", $signed(acc_i), 8);
    check("neg4_acc_q", $signed(acc_q), 0);
    wait_valid(2100, at2, ok);
    check("neg4_second_seen", ok, 1);
    check("neg4_period", at2 - at, 2046);
    check("neg4_second_acc_i", $signed(acc_i), 8);

    // Carrier rotation seen through accumulator deltas (chip 0 is 1, so the sign is flipped).
    @(negedge clk); reset = 1; real_in = 3'd1; carr_freq = 32'h4000_0000; code_freq = 32'd0;
    @(negedge clk); reset = 0;
    @(negedge clk);
    pi = $signed(dut.accum_i); pq = $signed(dut.accum_q);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      ci = $signed(dut.accum_i); cq = $signed(dut.accum_q);
      check("rot_delta_i", ci - pi, exp_di[(j-1)%4]);
      check("rot_delta_q", cq - pq, exp_dq[(j-1)%4]);
      pi = ci; pq = cq;
    end

    // Backpressure across two epochs: first result held, second dropped, overrun set.
    @(negedge clk); reset = 1; carr_freq = 32'd0; code_freq = 32'h8000_0000; out_ready = 0;
    @(negedge clk); reset = 0;
    wait_valid(2100, at, ok);
    check("hold_first_seen", ok, 1);
    check("hold_first_acc_i", $signed(acc_i), -2);
    real_in = 3'b100;
    ok = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin ok = 1; break; end
    end
    check("hold_overrun_set", ok, 1);
    check("hold_kept_acc_i", $signed(acc_i), -2);
    check("hold_kept_valid", out_valid, 1);
    out_ready = 1;
    @(negedge clk);
    check("hold_transferred", out_valid, 0);
    check("hold_overrun_sticky", overrun, 1);

    // Enable dropped mid-epoch: the partial epoch yields nothing, the next epoch is clean.
    @(negedge clk); reset = 1; real_in = 3'd1;
    @(negedge clk); reset = 0;
    repeat (1000) @(negedge clk);
    enable = 0;
    repeat (5) begin
      @(negedge clk);
      check("idle_no_valid", out_valid, 0);
    end
    enable = 1; first = cyc + 1;
    wait_valid(2100, at, ok);
    check("restart_seen", ok, 1);
    check("restart_latency", at - first, 2047);
    check("restart_acc_i", $signed(acc_i), -2);

    // Randomised run against the model.
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    idle_left = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      real_in = 3'($urandom);
      imag_in = 3'($urandom);
      if (n % 2500 == 0) begin
        ca_sel    = 6'($urandom);
        carr_freq = $urandom;
        code_freq = $urandom | 32'h8000_0000;
      end
      out_ready = ((n / 1500) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (idle_left > 0) idle_left--;
      else if ($urandom_range(0, 2999) == 0) idle_left = $urandom_range(1, 6);
      enable = (idle_left == 0);
      reset  = ($urandom_range(0, 7999) == 0);
    end
    reset = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gps_correlator_channel.md
GPS_CORRELATOR_CHANNEL -- requirements
Module: gps_correlator_channel

Interface
REQ-001 SHALL have parameter ACC_W, default 24, width of each signed accumulator output.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1: high means one sample is consumed every clk; low means idle.
REQ-005 SHALL have port real_in, input, 3, in-phase sample in signed two's complement (-4..+3).
REQ-006 SHALL have port imag_in, input, 3, quadrature sample in signed two's complement (-4..+3).
REQ-007 SHALL have port carr_freq, input, 32, carrier NCO phase increment per sample (2^32 = one cycle).
REQ-008 SHALL have port code_freq, input, 32, code NCO phase increment per sample; a carry-out advances one chip (4 Msps nominal: 1098437885).
REQ-009 SHALL have port ca_sel, input, 6: values 0-35 select PRN 1-36; values 36-63 select PRN 36.
REQ-010 SHALL have port acc_i, output, ACC_W, signed prompt in-phase integration result.
REQ-011 SHALL have port acc_q, output, ACC_W, signed prompt quadrature integration result.
REQ-012 SHALL have port out_valid, output, 1, which qualifies acc_i/acc_q.
REQ-013 SHALL have port out_ready, input, 1, the consumer's accept signal.
REQ-014 SHALL have port overrun, output, 1, a sticky flag that a completed epoch result was dropped.

Function
REQ-015 SHALL have two states: IDLE (enable low) and RUN (enable high); IDLE->RUN and RUN->IDLE both take effect on the clk edge sampling the new enable value.
REQ-016 SHALL, in IDLE, hold all internal state as follows:
- carrier phase and code phase at 0;
- G1 and G2 10-bit LFSRs at all-ones;
- chip counter at 0;
- accumulators at 0;
- any not-yet-registered epoch result discarded;
- out_valid, acc_i, acc_q and overrun unaffected.
REQ-017 SHALL generate C/A code per IS-GPS-200: G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10; chip = G1[10] XOR (G2 tap pair for the selected PRN).
REQ-018 SHALL map chip 0 to +1 and chip 1 to -1.
REQ-019 SHALL, each RUN cycle, use carrier-phase bits [31:30]=k to rotate the sample: k=0 -> (I,Q); k=1 -> (Q,-I); k=2 -> (-I,-Q); k=3 -> (-Q,I).
REQ-020 SHALL multiply the rotated sample by the current chip, sign-extend it to ACC_W, and add it to the accumulators; negating -4 SHALL yield +4 with no wrap.
REQ-021 SHALL, each RUN cycle, apply the current phases and chip to the current sample, then add carr_freq and code_freq modulo 2^32.
REQ-022 SHALL, on a code carry, advance both LFSRs one step and increment the chip counter; at count 1022 the counter wraps to 0, both LFSRs reload all-ones, and that cycle's sample is the last sample of the epoch.
REQ-023 SHALL compute accumulators without saturation, using modulo-2^ACC_W arithmetic.
REQ-024 SHALL, on the last sample of an epoch, register accumulator-plus-contribution as the epoch result and clear the accumulators to 0 in the same cycle; the next sample starts the new epoch.
REQ-025 SHALL pipeline the datapath so out_valid rises exactly 2 clk after the edge that sampled the last epoch sample.
REQ-026 SHALL use a one-entry output register with valid/ready handshake:
- transfer occurs when out_valid && out_ready;
- acc_i and acc_q are held stable while out_valid is high and out_ready is low.
REQ-027 SHALL, if a new epoch result arrives while out_valid is high and out_ready is low, drop the new result, keep the held result, and set overrun.
REQ-028 SHALL, if a new epoch result arrives in the same cycle as a transfer, load the new result and keep out_valid high.
REQ-029 SHALL apply ca_sel, carr_freq and code_freq changes on the next cycle without resetting phases.

Reset
REQ-030 SHALL, on reset, force state IDLE, all phases 0, both LFSRs all-ones, chip counter 0, accumulators 0, pipeline empty, acc_i=0, acc_q=0, out_valid=0 and overrun=0.
REQ-031 SHALL give reset priority over enable, the handshake and all epoch events, including when asserted mid-epoch or mid-handshake.

Verification
REQ-032 SHALL cover: reset asserted with enable=1 -> all outputs 0 throughout; first RUN cycle is the cycle after reset deasserts.
REQ-033 SHALL cover: ca_sel=0, code_freq=0x80000000, carr_freq=0, real_in=+1, imag_in=0, out_ready=1 -> first 10 chips 1100100000; out_valid 2 clk after sample 2046; acc_i=-2; acc_q=0; overrun=0.
REQ-034 SHALL cover: same as REQ-033 with real_in=-4 -> acc_i=+8, acc_q=0, repeating every 2046 samples.
REQ-035 SHALL cover: carr_freq=0x40000000, code_freq=0, real_in=+1, imag_in=0 -> rotated outputs (1,0),(0,-1),(-1,0),(0,1) repeating, checked through accumulator deltas.
REQ-036 SHALL cover: the REQ-033 setup with out_ready=0 for 2 epochs -> first result held unchanged, overrun=1 after second epoch end, out_ready=1 then transfers the first result.
REQ-037 SHALL cover: enable dropped at sample 1000 of an epoch, then reasserted -> no out_valid from the partial epoch; next result identical to REQ-033 (acc_i=-2).
